// File: rtl/syncfifo_ft.sv
// Single-clock first-word-fall-through FIFO with an explicit occupancy count,
// programmable almost-full/almost-empty flags, a synchronous flush and sticky
// overflow/underflow error flags. All status flags are registered and derived
// from the next-state count, so they agree with count in every cycle.
module syncfifo_ft #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wpush,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  wafull,
    input  logic                  rpull,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic                  rafempty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wfull_q, wfull_d;
    logic                  wafull_q, wafull_d;
    logic                  rempty_q, rempty_d;
    logic                  rafempty_q, rafempty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push_ok, pull_ok;

    // Next-state logic: accept rules, pointer/count update, sticky errors, flags.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch; blocking '=' is correct here.
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push_ok     = wpush & (~wfull_q | rpull);
        pull_ok     = rpull & ~rempty_q;

        if (flush) begin
            // Requests coinciding with flush are discarded, including the write.
            push_ok     = 1'b0;
            pull_ok     = 1'b0;
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_ok) wptr_d = wptr_q + ADDR_WIDTH'(1);
            if (pull_ok) rptr_d = rptr_q + ADDR_WIDTH'(1);
            count_d     = count_q + CW'(push_ok) - CW'(pull_ok);
            overflow_d  = overflow_q  | (wpush & wfull_q & ~rpull);
            underflow_d = underflow_q | (rpull & rempty_q);
        end

        wfull_d    = (count_d == DEPTH_C);
        rempty_d   = (count_d == '0);
        wafull_d   = (count_d >= AFULL_C);
        rafempty_d = (count_d <= AEMPTY_C);
    end

    // Control state: pointers, occupancy, registered flags.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples its next value from the same pre-edge snapshot.
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            wfull_q     <= 1'b0;
            wafull_q    <= 1'b0;
            rempty_q    <= 1'b1;
            rafempty_q  <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            wfull_q     <= wfull_d;
            wafull_q    <= wafull_d;
            rempty_q    <= rempty_d;
            rafempty_q  <= rafempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array: written on every accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately left out of reset; the
        // pointers and count alone define which entries are meaningful.
        if (push_ok) mem_q[wptr_q] <= wdata;
    end

    assign rdata     = mem_q[rptr_q];
    assign wfull     = wfull_q;
    assign wafull    = wafull_q;
    assign rempty    = rempty_q;
    assign rafempty  = rafempty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_syncfifo_ft.sv
// Scoreboard bench for syncfifo_ft: the driver keeps a queue-based reference
// of the FIFO contents and an occupancy/error model; a separate monitor pops
// the expected word whenever the DUT accepts a pull and compares rdata.
module tb_syncfifo_ft;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;
    localparam int AF = DEPTH - 2;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          wpush = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          rpull = 1'b0;
    logic          wfull, wafull, rempty, rafempty, overflow, underflow;
    logic [DW-1:0] rdata;
    logic [AW:0]   count;

    int total = 0;
    int bad = 0;

    // Reference model: contents as a queue, plus sticky error bits.
    logic [DW-1:0] exp_q[$];
    int            m_cnt = 0;
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;

    syncfifo_ft #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .AFULL_LEVEL (AF),
        .AEMPTY_LEVEL(AE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wpush    (wpush),
        .wdata    (wdata),
        .wfull    (wfull),
        .wafull   (wafull),
        .rpull    (rpull),
        .rdata    (rdata),
        .rempty   (rempty),
        .rafempty (rafempty),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every status output (and the visible head word) against the model.
    task automatic check_status(input string tag);
        check({tag, ".count"},     64'(count),     64'(m_cnt));
        check({tag, ".wfull"},     64'(wfull),     64'(m_cnt == DEPTH));
        check({tag, ".wafull"},    64'(wafull),    64'(m_cnt >= AF));
        check({tag, ".rempty"},    64'(rempty),    64'(m_cnt == 0));
        check({tag, ".rafempty"},  64'(rafempty),  64'(m_cnt <= AE));
        check({tag, ".overflow"},  64'(overflow),  64'(m_ovf));
        check({tag, ".underflow"}, 64'(underflow), 64'(m_udf));
        if (m_cnt > 0 && exp_q.size() > 0)
            check({tag, ".head"}, 64'(rdata), 64'(exp_q[0]));
    endtask

    // Issue one cycle of stimulus, update the model, then check after the edge.
    task automatic step(input string tag, input bit p, input logic [DW-1:0] d,
                        input bit l, input bit f);
        bit full, empty, pok, lok;
        wpush = p;
        wdata = d;
        rpull = l;
        flush = f;
        if (f) begin
            m_cnt = 0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
            exp_q.delete();
        end else begin
            full  = (m_cnt == DEPTH);
            empty = (m_cnt == 0);
            pok   = p && (!full || l);
            lok   = l && !empty;
            if (p && full && !l) m_ovf = 1'b1;
            if (l && empty)      m_udf = 1'b1;
            if (pok) exp_q.push_back(d);
            m_cnt = m_cnt + int'(pok) - int'(lok);
        end
        @(posedge clk);
        #1;
        wpush = 1'b0;
        rpull = 1'b0;
        flush = 1'b0;
        check_status(tag);
    endtask

    // Monitor: every accepted pull must present the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rpull && !rempty && !flush) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_data: got %0h expected nothing (t=%0t)", rdata, $time);
            end else begin
                check("pop_data", 64'(rdata), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #2;
        check_status("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        step("idle", 0, '0, 0, 0);

        // Fill 0..15: wafull at 14, wfull at 16, then a dropped push of 99.
        for (int i = 0; i < DEPTH; i++) step("fill", 1, DW'(i), 0, 0);
        step("ovf_push", 1, 32'd99, 0, 0);
        check("ovf_set", 64'(overflow), 64'd1);
        for (int i = 0; i < DEPTH; i++) step("drain", 0, '0, 1, 0);

        // Refill, then 40 cycles of simultaneous push and pull at full.
        for (int i = 0; i < DEPTH; i++) step("refill", 1, DW'(100 + i), 0, 0);
        for (int i = 0; i < 40; i++) step("full_stream", 1, DW'(100 + DEPTH + i), 1, 0);
        check("stream_count", 64'(count), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) step("drain2", 0, '0, 1, 0);

        // Pull from empty, then push(5)+pull from empty.
        step("udf_pull", 0, '0, 1, 0);
        check("udf_set", 64'(underflow), 64'd1);
        step("push5_pull", 1, 32'd5, 1, 0);
        check("push5_rdata", 64'(rdata), 64'd5);
        check("push5_count", 64'(count), 64'd1);

        // Push 7 more, then flush with a concurrent push, then push(42).
        for (int i = 0; i < 7; i++) step("pre_flush", 1, DW'(200 + i), 0, 0);
        step("flush", 1, 32'd77, 0, 1);
        check("flush_count", 64'(count), 64'd0);
        step("push42", 1, 32'd42, 0, 0);
        check("push42_rdata", 64'(rdata), 64'd42);
        step("pop42", 0, '0, 1, 0);

        // Asynchronous reset mid-stream at count 9.
        for (int i = 0; i < 9; i++) step("pre_rst", 1, DW'(300 + i), 0, 0);
        check("pre_rst_count", 64'(count), 64'd9);
        #2 rst = 1'b1;
        m_cnt = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        exp_q.delete();
        #1;
        check_status("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        check_status("post_rst");
        step("resume_push", 1, 32'h1234_5678, 0, 0);
        step("resume_pull", 0, '0, 1, 0);

        // Randomised traffic: alternating fill-biased and drain-biased phases.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 100; i++) begin
                int pp, pl;
                pp = (ph % 2 == 0) ? 80 : 25;
                pl = (ph % 2 == 0) ? 25 : 80;
                step("rand", $urandom_range(0, 99) < pp, DW'($urandom),
                     $urandom_range(0, 99) < pl, $urandom_range(0, 63) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/syncfifo_ft.md
# syncfifo_ft

Single-clock, parametrised first-word-fall-through FIFO. It is the same-clock counterpart of the pipeline's clock-crossing FIFO and keeps the same push/pull port vocabulary. Beyond plain buffering it adds an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It is the intended buffer for in-domain queues such as fetch, store, and MMIO request paths.

## Interface
Parameters:
- DATA_WIDTH, 32, payload width in bits
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 1 << ADDR_WIDTH (minimum ADDR_WIDTH = 1)
- AFULL_LEVEL, DEPTH-2, wafull asserted when count >= AFULL_LEVEL (legal range 1..DEPTH)
- AEMPTY_LEVEL, 2, rafempty asserted when count <= AEMPTY_LEVEL (legal range 0..DEPTH-1)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of contents and error flags
- wpush  input  1  write request
- wdata  input  DATA_WIDTH  write payload, sampled with wpush
- wfull  output  1  FIFO holds DEPTH entries
- wafull  output  1  almost full
- rpull  input  1  read request; pops the head entry
- rdata  output  DATA_WIDTH  head entry; valid whenever rempty = 0
- rempty  output  1  FIFO holds 0 entries
- rafempty  output  1  almost empty
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a push was dropped
- underflow  output  1  sticky: a pull was ignored

## Operation
- Storage: DEPTH x DATA_WIDTH register array. Write pointer and read pointer are each ADDR_WIDTH bits and wrap naturally modulo DEPTH. count is kept as an explicit register.
- Accept rules, evaluated in the same cycle:
  - push_ok = wpush & (!wfull | rpull)
  - pull_ok = rpull & !rempty
- Push while full with a simultaneous pull: both the push and the pull are accepted; count is unchanged.
- Pull while empty with a simultaneous push: the pull is ignored and underflow is set. The push is accepted; count becomes 1.
- Dropped push (wpush & wfull & !rpull): memory and pointers are unchanged; overflow is set.
- Ignored pull (rpull & rempty): state is unchanged apart from underflow.
- count_next = count + push_ok - pull_ok.
- Status flags: wfull, rempty, wafull, and rafempty are registered and computed from count_next, so they always agree with count in the same cycle.
- rdata = mem[rptr], read combinationally (first-word fall-through). When rempty = 1, rdata holds the last value at that location and is don't-care.
- flush: pointers, count, overflow, and underflow all go to 0; rempty = 1. A wpush or rpull in the same cycle as flush is discarded. Memory contents are not cleared.
- Priority: rst > flush > push/pull.
- rst: asynchronous assertion; outputs take their reset values immediately. Deassertion is expected synchronous to clk; the block performs no internal reset synchronisation.

## Timing
Reset values:
- count = 0
- rempty = 1, rafempty = 1 (since 0 <= AEMPTY_LEVEL)
- wfull = 0, wafull = 0
- overflow = 0, underflow = 0
- rdata is undefined, because memory is not reset.

Latency and handshake:
- Write-to-read latency is 1 cycle. For a push accepted at edge T, rempty falls and rdata shows that word after edge T, so a pull can be issued in cycle T+1.
- After a pull accepted at edge T, rdata shows the next entry after edge T.
- wfull rises after the edge that makes count = DEPTH. It falls after the edge of the first accepted pull.
- Throughput is one push and one pull per cycle, sustained indefinitely at any occupancy from 1 to DEPTH-1, and also at DEPTH when push and pull arrive together.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble. Data order is strictly FIFO across the wrap.
- Sticky flags set on the edge following the offending request and hold until rst or flush.

## Test plan
- Reset, then idle: count = 0, rempty = 1, rafempty = 1, wfull = 0, overflow = 0, underflow = 0.
- With DEPTH = 16, push 0..15 on consecutive cycles:
  - wafull asserts after the 14th push (count = 14); wfull asserts after the 16th.
  - A 17th push of value 99 sets overflow and is dropped.
  - Draining yields 0..15 in order, then rempty = 1.
- Fill to 16, then drive push and pull together for 40 cycles with incrementing data: count stays 16, wfull stays 1, overflow stays 0, and the popped sequence is continuous across 2+ pointer wraps.
- From empty, assert rpull alone: underflow = 1 and count = 0. Then assert push(5) and pull together: count = 1, rdata = 5, rempty falls after 1 edge.
- Push 7 words, then assert flush together with wpush: count = 0, rempty = 1, overflow and underflow cleared, and the flush-cycle push is discarded. A subsequent push(42) appears on rdata after 1 edge.
- Assert rst asynchronously mid-stream at count = 9: all outputs go to their reset values before the next clk edge, and normal operation resumes after rst is released.
